// File: rtl/key_schedule_controller_pkg.sv
// Shared types, constants and byte-level helpers for the AES-128 key schedule engine.
package key_schedule_controller_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Round constants for rounds 1..10, round 1 in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rounds outside 1..10 map to zero.
  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] round);
    logic [7:0] r;
    r = '0;
    case (round)
      4'd1:    r = RCON_TABLE[79:72];
      4'd2:    r = RCON_TABLE[71:64];
      4'd3:    r = RCON_TABLE[63:56];
      4'd4:    r = RCON_TABLE[55:48];
      4'd5:    r = RCON_TABLE[47:40];
      4'd6:    r = RCON_TABLE[39:32];
      4'd7:    r = RCON_TABLE[31:24];
      4'd8:    r = RCON_TABLE[23:16];
      4'd9:    r = RCON_TABLE[15:8];
      4'd10:   r = RCON_TABLE[7:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Byte b lives at bit offset 8*(255-b), i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] ofs;
    ofs = {~b, 3'b000};
    return SBOX_TABLE[ofs +: 8];
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_schedule_controller_round.sv
// Single AES-128 key expansion round: derives round key r from round key r-1.
module key_schedule_controller_round
  import key_schedule_controller_pkg::*;
(
  input  logic [IDX_W-1:0] roundCount,
  input  logic [KEY_W-1:0] keyIn,
  output logic [KEY_W-1:0] keyOut
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] temp;
  logic [WORD_W-1:0] o0, o1, o2, o3;

  assign w0 = keyIn[127:96];
  assign w1 = keyIn[95:64];
  assign w2 = keyIn[63:32];
  assign w3 = keyIn[31:0];

  assign temp = sub_word(rot_word(w3)) ^ {rcon(roundCount), 24'h000000};

  // Chained XOR: each output word folds in the previous output word.
  assign o0 = w0 ^ temp;
  assign o1 = w1 ^ o0;
  assign o2 = w2 ^ o1;
  assign o3 = w3 ^ o2;

  assign keyOut = {o0, o1, o2, o3};

endmodule

// File: rtl/key_schedule_controller.sv
// Sequential AES-128 key schedule: one shared expansion round per clock into an
// 11-entry round-key file, with a registered random-access read port.
module key_schedule_controller
  import key_schedule_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] keyIn,
  output logic             busy,
  output logic             done,
  output logic             keysReady,
  input  logic [IDX_W-1:0] readIndex,
  output logic [KEY_W-1:0] readKey,
  output logic             readValid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic [IDX_W-1:0] valid_q, valid_d;
  logic             busy_d, done_d, ready_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0] wr_data;

  logic [IDX_W-1:0] prev_idx;
  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] step_key;

  logic [KEY_W-1:0] key_rf [NUM_KEYS];

  // Source of the shared round: key[roundCount-1].
  assign prev_idx = (round_q == '0) ? '0 : round_q - IDX_W'(1);
  assign prev_key = key_rf[prev_idx];

  key_schedule_controller_round u_round (
    .roundCount (round_q),
    .keyIn      (prev_key),
    .keyOut     (step_key)
  );

  // Next-state, counters, flags and register-file write control.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy;
    done_d  = 1'b0;
    ready_d = keysReady;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = step_key;

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_data = keyIn;
          round_d = IDX_W'(1);
          valid_d = IDX_W'(1);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en   = 1'b1;
        wr_idx  = round_q;
        wr_data = step_key;
        valid_d = round_q + IDX_W'(1);
        if (round_q == LAST_IDX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          round_d = round_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      round_q   <= '0;
      valid_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      keysReady <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      valid_q   <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      keysReady <= ready_d;
    end
  end

  // Register file contents are masked by valid_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_rf[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readKey   <= '0;
      readValid <= 1'b0;
    end else begin
      readKey   <= (readIndex <= LAST_IDX) ? key_rf[readIndex] : '0;
      readValid <= (readIndex < valid_q);
    end
  end

endmodule

// File: tb/tb_key_schedule_controller.sv
// Self-checking bench for key_schedule_controller: directed FIPS-197 scenarios plus
// randomized traffic compared every cycle against a behavioural key-schedule model.
module tb_key_schedule_controller;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] keyIn;
  logic         busy;
  logic         done;
  logic         keysReady;
  logic [3:0]   readIndex;
  logic [127:0] readKey;
  logic         readValid;

  int checks = 0;
  int errors = 0;

  key_schedule_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .keyIn     (keyIn),
    .busy      (busy),
    .done      (done),
    .keysReady (keysReady),
    .readIndex (readIndex),
    .readKey   (readKey),
    .readValid (readValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic (GF(2^8) based) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = xtime(c);
    return c;
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t, o0, o1, o2, o3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rcon_of(r), 24'h000000};
    o0 = w0 ^ t; o1 = w1 ^ o0; o2 = w2 ^ o1; o3 = w3 ^ o2;
    return {o0, o1, o2, o3};
  endfunction

  // ---------------- behavioural model state ----------------
  logic [127:0] exp_keys [11];
  bit           model_ok  = 0;
  bit           m_run     = 0;
  int           m_since   = 0;
  int           m_vcnt    = 0;
  bit           e_busy    = 0;
  bit           e_done    = 0;
  bit           e_ready   = 0;
  bit           e_rvalid  = 0;
  bit           e_rkey_on = 0;
  logic [127:0] e_rkey    = '0;

  always @(posedge clk) begin
    int ri;
    if (reset) begin
      m_run = 0; m_since = 0; m_vcnt = 0;
      e_busy = 0; e_done = 0; e_ready = 0;
      e_rvalid = 0; e_rkey_on = 1; e_rkey = '0;
      model_ok = 1;
    end else begin
      // The read sees the key file as it stood before this edge.
      ri        = int'(readIndex);
      e_rvalid  = (ri < m_vcnt);
      e_rkey_on = e_rvalid || (ri > 10);
      e_rkey    = (ri > 10) ? '0 : exp_keys[ri];
      e_done    = 0;
      if (!m_run && start) begin
        exp_keys[0] = keyIn;
        for (int r = 1; r <= 10; r++) exp_keys[r] = model_round(exp_keys[r-1], r);
        m_run = 1; m_since = 0; m_vcnt = 1; e_ready = 0;
      end else if (m_run) begin
        m_since++;
        m_vcnt = m_since + 1;
        if (m_since == 10) begin
          m_run = 0; e_done = 1; e_ready = 1;
        end
      end
      e_busy = m_run;
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk1("busy", busy, e_busy);
      chk1("done", done, e_done);
      chk1("keysReady", keysReady, e_ready);
      chk1("readValid", readValid, e_rvalid);
      if (e_rkey_on) chk128("readKey", readKey, e_rkey);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk1(name, done, 1'b1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    int edges;
    int first_valid;
    bit saw_done;
    logic [127:0] key_a;

    // S-box from multiplicative inverse plus affine transform.
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[a] = b;
    end

    reset = 1'b1; start = 1'b0; keyIn = '0; readIndex = 4'd0;
    repeat (3) step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", keysReady, 1'b0);
    chk1("rst_rvalid", readValid, 1'b0);
    chk128("rst_rkey", readKey, '0);
    reset = 1'b0;
    step();

    // FIPS-197 vector, polling index 5 throughout.
    start = 1'b1; keyIn = FIPS_KEY; readIndex = 4'd5;
    step();
    start = 1'b0;
    edges = 1; first_valid = -1;
    while (!done && edges < 20) begin
      if (readValid && first_valid < 0) first_valid = edges;
      step();
      edges++;
    end
    chki("fips_done_edge", edges, 11);
    chki("poll5_first_valid_edge", first_valid, 7);
    chk128("model_rk1", exp_keys[1], FIPS_RK1);
    chk128("model_rk10", exp_keys[10], FIPS_RK10);
    chk1("fips_ready", keysReady, 1'b1);
    step();
    chk1("done_one_cycle", done, 1'b0);
    readIndex = 4'd1;
    step();
    chk128("fips_rk1", readKey, FIPS_RK1);
    readIndex = 4'd10;
    step();
    chk128("fips_rk10", readKey, FIPS_RK10);
    for (int i = 11; i < 16; i++) begin
      readIndex = 4'(i);
      step();
      chk128("oob_key", readKey, '0);
      chk1("oob_valid", readValid, 1'b0);
    end

    // Start at E3 is ignored; start on the done cycle is accepted.
    key_a = rand128();
    start = 1'b1; keyIn = key_a; readIndex = 4'd0;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; keyIn = rand128();
    step();
    start = 1'b0;
    wait_done("restart_done", 20);
    start = 1'b1; keyIn = '0; readIndex = 4'd0;
    step();
    start = 1'b0;
    chk128("restart_key0_unchanged", readKey, key_a);
    chk1("done_cycle_start_accepted", busy, 1'b1);
    wait_done("zero_done", 20);
    readIndex = 4'd10;
    step();
    chk128("zero_rk10", readKey, ZERO_RK10);

    // Reset sampled at E6 aborts the run.
    start = 1'b1; keyIn = rand128();
    step();
    start = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", keysReady, 1'b0);
    saw_done = done;
    for (int i = 0; i <= 10; i++) begin
      readIndex = 4'(i);
      step();
      chk1("abort_rvalid", readValid, 1'b0);
      saw_done = saw_done | done;
    end
    chk1("abort_no_done", saw_done, 1'b0);

    // Randomized traffic, checked by the every-cycle comparator.
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 9) == 0);
      keyIn     = rand128();
      readIndex = 4'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
